// File: rtl/i2c_eeprom_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_slave_if
// Two-wire bus bundle between the EEPROM master (or a bench) and the
// i2c_eeprom_slave responder.
//   SCL     serial clock driven by the master
//   SDA_IN  resolved (wired-AND) level of the SDA line
//   SDA_OE  slave pull-down enable: 1 = pull SDA low, 0 = release
// The master side owns the line resolution, so it drives SDA_IN after
// combining its own drive with SDA_OE.
// -----------------------------------------------------------------------------
interface i2c_eeprom_slave_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OE;

  modport slave (
    input  SCL,
    input  SDA_IN,
    output SDA_OE
  );

  modport master (
    output SCL,
    output SDA_IN,
    input  SDA_OE
  );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_slave
// 24C16-style two-wire serial EEPROM responder with on-chip storage.
// Decodes START/STOP, the control byte (DEV_CODE + page bits + R/W), the word
// address, write data and read data, and drives ACK and read bits through an
// open-drain pull-down enable.
//
// Ports:
//   CLK        system clock, at least 8x the SCL frequency
//   RESET      synchronous, active-high
//   bus        slave modport: SCL, SDA_IN in, SDA_OE out
//   BUSY       high from a matched control byte until STOP / reset
//   WR_STROBE  one-CLK pulse per byte committed to storage
//   WR_ADDR    address of the last committed byte
//   WR_DATA    value of the last committed byte
// -----------------------------------------------------------------------------
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_CODE = 4'b1010,
  parameter int         ADDR_W   = 11,
  parameter int         DEPTH    = 2048
) (
  input  logic              CLK,
  input  logic              RESET,
  i2c_eeprom_slave_if.slave bus,
  output logic              BUSY,
  output logic              WR_STROBE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CTRL   = 3'd1;
  localparam logic [2:0] ST_ACK    = 3'd2;
  localparam logic [2:0] ST_ADDR   = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_RACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Synchronizers plus history flops; they idle high like the bus itself so
  // that leaving reset never looks like an edge.
  logic sclSync1_q, sclSync2_q, sclPrev_q;
  logic sdaSync1_q, sdaSync2_q, sdaPrev_q;

  logic [2:0]        state_q, state_d;
  logic [2:0]        ackNext_q, ackNext_d;
  logic              ackDrv_q, ackDrv_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sdaOe_q, sdaOe_d;
  logic              busy_q, busy_d;
  logic              wrStrobe_q, wrStrobe_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]        wrData_q, wrData_d;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] memRdAddr;
  logic [7:0]        memRdata;
  logic              memWe;

  logic sclRise, sclFall, sdaRise, sdaFall, startDet, stopDet;
  logic [7:0] rxByte;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sclSync1_q <= 1'b1;
      sclSync2_q <= 1'b1;
      sclPrev_q  <= 1'b1;
      sdaSync1_q <= 1'b1;
      sdaSync2_q <= 1'b1;
      sdaPrev_q  <= 1'b1;
    end else begin
      sclSync1_q <= bus.SCL;
      sclSync2_q <= sclSync1_q;
      sclPrev_q  <= sclSync2_q;
      sdaSync1_q <= bus.SDA_IN;
      sdaSync2_q <= sdaSync1_q;
      sdaPrev_q  <= sdaSync2_q;
    end
  end

  assign sclRise  = ~sclPrev_q & sclSync2_q;
  assign sclFall  = sclPrev_q & ~sclSync2_q;
  assign sdaRise  = ~sdaPrev_q & sdaSync2_q;
  assign sdaFall  = sdaPrev_q & ~sdaSync2_q;
  assign startDet = sdaFall & sclSync2_q;
  assign stopDet  = sdaRise & sclSync2_q;

  // Byte as it stands once the bit sampled on this SCL rise is shifted in.
  assign rxByte = {shift_q[6:0], sdaSync2_q};

  // In RACK the next byte is fetched ahead of the pointer update.
  assign memRdAddr = (state_q == ST_RACK) ? (ptr_q + PTR_ONE) : ptr_q;
  assign memRdata  = mem[memRdAddr];

  // Protocol engine. STOP and START override whatever the current state is.
  // All ACK phases share ST_ACK; ackNext_q remembers where to go once the
  // ACK bit has been released, and doubles as the latched R/W direction.
  always_comb begin
    state_d    = state_q;
    ackNext_d  = ackNext_q;
    ackDrv_d   = ackDrv_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sdaOe_d    = sdaOe_q;
    busy_d     = busy_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    memWe      = 1'b0;

    if (stopDet) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sdaOe_d  = 1'b0;
      ackDrv_d = 1'b0;
      bitCnt_d = 4'd0;
    end else if (startDet) begin
      state_d  = ST_CTRL;
      sdaOe_d  = 1'b0;
      ackDrv_d = 1'b0;
      bitCnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_CTRL, ST_ADDR, ST_WDATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = 4'd0;
              state_d  = ST_ACK;
              if (state_q == ST_CTRL) begin
                if (rxByte[7:4] == DEV_CODE) begin
                  ptr_d[ADDR_W-1:8] = rxByte[ADDR_W-8:1];
                  busy_d            = 1'b1;
                  ackNext_d         = rxByte[0] ? ST_RDATA : ST_ADDR;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_ADDR) begin
                ptr_d[7:0] = rxByte;
                ackNext_d  = ST_WDATA;
              end else begin
                memWe      = 1'b1;
                wrStrobe_d = 1'b1;
                wrAddr_d   = ptr_q;
                wrData_d   = rxByte;
                ptr_d      = ptr_q + PTR_ONE;
                ackNext_d  = ST_WDATA;
              end
            end
          end
        end

        // First fall pulls SDA low, second fall releases. For a read the
        // release fall is also where the first data bit has to appear.
        ST_ACK: begin
          if (sclFall) begin
            if (!ackDrv_q) begin
              sdaOe_d  = 1'b1;
              ackDrv_d = 1'b1;
            end else begin
              ackDrv_d = 1'b0;
              sdaOe_d  = 1'b0;
              bitCnt_d = 4'd0;
              state_d  = ackNext_q;
              if (ackNext_q == ST_RDATA) begin
                sdaOe_d  = ~memRdata[7];
                shift_d  = {memRdata[6:0], 1'b0};
                bitCnt_d = 4'd1;
              end
            end
          end
        end

        // bitCnt_q counts bits already put on the line; the fall after the
        // eighth bit hands SDA back to the master for its ACK.
        ST_RDATA: begin
          if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              sdaOe_d  = 1'b0;
              bitCnt_d = 4'd0;
              state_d  = ST_RACK;
            end else begin
              sdaOe_d  = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end

        // Pointer advances on ACK and NACK alike, so a later current-address
        // read continues after the last byte sent.
        ST_RACK: begin
          if (sclRise) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!sdaSync2_q) begin
              shift_d  = memRdata;
              bitCnt_d = 4'd0;
              state_d  = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      ackNext_q  <= ST_ADDR;
      ackDrv_q   <= 1'b0;
      bitCnt_q   <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      ackNext_q  <= ackNext_d;
      ackDrv_q   <= ackDrv_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sdaOe_q    <= sdaOe_d;
      busy_q     <= busy_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[ptr_q] <= rxByte;
    end
  end

  assign bus.SDA_OE = sdaOe_q;
  assign BUSY       = busy_q;
  assign WR_STROBE  = wrStrobe_q;
  assign WR_ADDR    = wrAddr_q;
  assign WR_DATA    = wrData_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Bench for i2c_eeprom_slave. A bit-banged master drives the bus interface;
// a transaction-level memory model predicts writes (queued for a separate
// WR_STROBE monitor) and read data.
// -----------------------------------------------------------------------------
module tb_i2c_eeprom_slave;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wrExp_t;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              BUSY;
  logic              WR_STROBE;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic              masterSda;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] refMem [DEPTH];
  int         refPtr;
  wrExp_t     expWrQ[$];
  logic [7:0] txData[$];

  logic watchNoDrive = 1'b0;
  logic sawOe        = 1'b0;

  i2c_eeprom_slave_if bus ();

  // Wired-AND of the master's drive and the slave's pull-down.
  assign bus.SDA_IN = masterSda & ~bus.SDA_OE;

  i2c_eeprom_slave #(
    .DEV_CODE(4'b1010),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .BUSY     (BUSY),
    .WR_STROBE(WR_STROBE),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Write monitor: every committed byte must match the oldest prediction.
  initial begin
    wrExp_t e;
    forever begin
      @(negedge CLK);
      if (WR_STROBE === 1'b1) begin
        testsRun++;
        if (expWrQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, required no write",
                   WR_ADDR, WR_DATA);
        end else begin
          e = expWrQ.pop_front();
          if (WR_ADDR !== e.addr || WR_DATA !== e.data) begin
            testsFailed++;
            $display("[TB] FAIL writeCommit: got addr 0x%0h data 0x%0h, required addr 0x%0h data 0x%0h",
                     WR_ADDR, WR_DATA, e.addr, e.data);
          end
        end
      end
    end
  end

  // Records any pull-down while a non-addressed transfer is in progress.
  initial begin
    forever begin
      @(negedge CLK);
      if (watchNoDrive && bus.SDA_OE === 1'b1) sawOe = 1'b1;
    end
  end

  initial begin
    #800000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Bus-level master primitives. SDA only moves while SCL is low except
  // inside START/STOP, with several CLKs of margin around every edge.
  task automatic i2cStart();
    masterSda = 1'b1; tick(4);
    bus.SCL   = 1'b1; tick(6);
    masterSda = 1'b0; tick(6);
    bus.SCL   = 1'b0; tick(4);
  endtask

  task automatic i2cStop();
    masterSda = 1'b0; tick(4);
    bus.SCL   = 1'b1; tick(6);
    masterSda = 1'b1; tick(4);
    checkOutput("busyAfterStop", BUSY, 0);
    checkOutput("oeAfterStop", bus.SDA_OE, 0);
    tick(6);
  endtask

  task automatic writeBit(input logic b);
    masterSda = b;    tick(4);
    bus.SCL   = 1'b1; tick(8);
    bus.SCL   = 1'b0; tick(4);
  endtask

  task automatic readBit(output logic b);
    masterSda = 1'b1; tick(4);
    bus.SCL   = 1'b1; tick(6);
    b = bus.SDA_IN;   tick(2);
    bus.SCL   = 1'b0; tick(4);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ack);
  endtask

  task automatic readByte(input logic ackBit, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) readBit(d[i]);
    writeBit(ackBit);
  endtask

  // Complete write transaction of txData to a matching device; the model
  // sets the pointer from page bits + address and stores each byte.
  task automatic applyStimulus(input logic [7:0] ctrl, input logic [7:0] addr);
    logic ack;
    refPtr = int'(ctrl[3:1]) * 256 + int'(addr);
    foreach (txData[k]) begin
      refMem[refPtr] = txData[k];
      expWrQ.push_back('{addr: refPtr[ADDR_W-1:0], data: txData[k]});
      refPtr = (refPtr + 1) % DEPTH;
    end
    i2cStart();
    writeByte(ctrl, ack);
    checkOutput("ackCtrlW", ack, 0);
    writeByte(addr, ack);
    checkOutput("ackAddr", ack, 0);
    foreach (txData[k]) begin
      writeByte(txData[k], ack);
      checkOutput("ackData", ack, 0);
    end
    i2cStop();
  endtask

  // Read of n bytes, optionally preceded by a dummy write to set the pointer.
  task automatic readTxn(input logic [7:0] ctrl, input logic [7:0] addr,
                         input bit dummy, input int n);
    logic       ack;
    logic [7:0] got;
    logic [7:0] exp;
    i2cStart();
    if (dummy) begin
      refPtr = int'(ctrl[3:1]) * 256 + int'(addr);
      writeByte({ctrl[7:1], 1'b0}, ack);
      checkOutput("ackDummyCtrl", ack, 0);
      writeByte(addr, ack);
      checkOutput("ackDummyAddr", ack, 0);
      i2cStart();
    end
    refPtr = int'(ctrl[3:1]) * 256 + (refPtr % 256);
    writeByte(ctrl, ack);
    checkOutput("ackCtrlR", ack, 0);
    for (int k = 0; k < n; k++) begin
      exp = refMem[refPtr];
      readByte(k == n - 1, got);
      checkOutput("readByte", got, exp);
      refPtr = (refPtr + 1) % DEPTH;
    end
    checkOutput("oeAfterNack", bus.SDA_OE, 0);
    i2cStop();
  endtask

  initial begin
    logic       ack;
    logic [2:0] page;
    logic [7:0] addr;
    int         len;

    RESET     = 1'b1;
    bus.SCL   = 1'b1;
    masterSda = 1'b1;
    refPtr    = 0;
    tick(5);
    checkOutput("resetSdaOe", bus.SDA_OE, 0);
    checkOutput("resetBusy", BUSY, 0);
    checkOutput("resetWrStrobe", WR_STROBE, 0);
    checkOutput("resetWrAddr", WR_ADDR, 0);
    checkOutput("resetWrData", WR_DATA, 0);
    RESET = 1'b0;
    tick(5);

    $display("[TB] byte write and random read");
    txData = '{8'h5A};
    applyStimulus(8'hA4, 8'h35);
    readTxn(8'hA5, 8'h35, 1'b1, 1);

    $display("[TB] sequential write across the top of memory");
    txData = '{8'h11, 8'h22};
    applyStimulus(8'hAE, 8'hFF);
    readTxn(8'hAF, 8'hFF, 1'b1, 2);

    $display("[TB] sequential read");
    txData = '{8'h01, 8'h02, 8'h03};
    applyStimulus(8'hA2, 8'h00);
    readTxn(8'hA3, 8'h00, 1'b1, 3);

    $display("[TB] device code mismatch");
    sawOe        = 1'b0;
    watchNoDrive = 1'b1;
    i2cStart();
    writeByte(8'hB0, ack);
    checkOutput("ackMismatchCtrl", ack, 1);
    checkOutput("busyMismatch", BUSY, 0);
    writeByte(8'h35, ack);
    checkOutput("ackMismatchByte", ack, 1);
    i2cStop();
    watchNoDrive = 1'b0;
    checkOutput("mismatchNeverDrives", sawOe, 0);

    $display("[TB] STOP after four data bits, then current-address read");
    txData = '{8'h77};
    applyStimulus(8'hA0, 8'h40);
    i2cStart();
    writeByte(8'hA0, ack);
    checkOutput("ackAbortCtrl", ack, 0);
    writeByte(8'h40, ack);
    checkOutput("ackAbortAddr", ack, 0);
    refPtr = 16'h040;
    for (int i = 0; i < 4; i++) writeBit(1'b0);
    i2cStop();
    readTxn(8'hA1, 8'h00, 1'b0, 1);

    $display("[TB] reset during read data");
    txData = '{8'h00};
    applyStimulus(8'hA6, 8'h10);
    i2cStart();
    writeByte(8'hA6, ack);
    writeByte(8'h10, ack);
    i2cStart();
    writeByte(8'hA7, ack);
    checkOutput("ackBeforeReset", ack, 0);
    checkOutput("oeBeforeReset", bus.SDA_OE, 1);
    RESET = 1'b1;
    tick(1);
    checkOutput("oeAfterReset", bus.SDA_OE, 0);
    bus.SCL   = 1'b1;
    masterSda = 1'b1;
    tick(3);
    RESET  = 1'b0;
    refPtr = 0;
    tick(5);
    checkOutput("busyAfterReset", BUSY, 0);

    $display("[TB] randomized write/read-back");
    for (int t = 0; t < 10; t++) begin
      page = 3'($urandom_range(0, 7));
      addr = 8'($urandom_range(0, 255));
      len  = int'($urandom_range(1, 4));
      txData.delete();
      for (int k = 0; k < len; k++) txData.push_back(8'($urandom_range(0, 255)));
      applyStimulus({4'hA, page, 1'b0}, addr);
      readTxn({4'hA, page, 1'b1}, addr, 1'b1, len);
    end

    tick(10);
    checkOutput("pendingWrites", expWrQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
